leaf_port_bridge: RTL and testbench

- Parametrised, buffered stream bridge between a leaf interface and the user kernel inside a leaf wrapper.
- Carries NUM_IN_PORTS interface-to-user channels and NUM_OUT_PORTS user-to-interface channels, each through its own first-word-fall-through FIFO.
- Per-channel full/empty/read monitoring counters and stall flags, plus resend-aware gating of the user-to-interface direction.
- Replaces direct wiring of kernel AXI-stream ports onto the interface vld/ack buses.

---
 rtl/leaf_port_bridge_pkg.sv | 27 ++
 rtl/leaf_port_bridge_chan.sv | 125 ++++++++++++
 rtl/leaf_port_bridge.sv | 89 ++++++++
 tb/tb_leaf_port_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_port_bridge_pkg.sv
// Shared helpers for the leaf port bridge: sizing math and counter saturation.
package leaf_port_bridge_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Ceiling log2 for sizing pointers. clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Pointer width for the default depth. Occupancy needs one more bit.
    localparam int FIFO_ADDR_BITS = clog2(DEFAULT_FIFO_DEPTH);

    // Increment enable for a saturating counter. It stays at all-ones once reached.
    function automatic logic sat_step(input logic inc, input logic at_max);
        return inc && !at_max;
    endfunction

endpackage

// File: rtl/leaf_port_bridge_chan.sv
// One bridge channel: FWFT FIFO, full/empty/read counters and a stall flag.
// rd_gate hides the head from the reader without disturbing the stored data.
module leaf_chan_fifo
    import leaf_port_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_BITS     = 32,
    parameter int STALL_CNT    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cnt_clear,
    input  logic                    rd_gate,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [CNT_BITS-1:0]     full_cnt,
    output logic [CNT_BITS-1:0]     empty_cnt,
    output logic [CNT_BITS-1:0]     read_cnt,
    output logic                    stall_condition
);

    localparam int ADDR_BITS = clog2(FIFO_DEPTH);
    localparam int RUN_BITS  = clog2(STALL_CNT + 1);
    localparam logic [ADDR_BITS:0]  DEPTH_C = (ADDR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0]  ONE_C   = (ADDR_BITS + 1)'(1);
    localparam logic [RUN_BITS-1:0] STALL_C = RUN_BITS'(STALL_CNT);

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]    wr_ptr;
    logic [ADDR_BITS-1:0]    rd_ptr;
    logic [ADDR_BITS:0]      count;
    logic [ADDR_BITS:0]      count_next;
    logic [RUN_BITS-1:0]     run;
    logic [RUN_BITS-1:0]     run_next;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign push     = wr_valid && wr_ready;
    assign rd_valid = !empty && !rd_gate;
    assign pop      = rd_valid && rd_ready;
    // Empty slots read as zero, so reset and drain show 0 data without clearing the array.
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        // NOTE: default assignment first, so no path leaves count_next unassigned and no latch is inferred.
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + ONE_C;
            2'b01:   count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    // Storage write. The array holds no control state.
    // NOTE: the memory is not reset; rd_data masks the stale contents while the channel is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            // Ready comes from occupancy only. A pop at full reopens the channel one cycle later.
            wr_ready <= (count_next != DEPTH_C);
        end
    end

    // Monitoring counters. They saturate, and a clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cnt  <= '0;
            empty_cnt <= '0;
            read_cnt  <= '0;
        end else if (cnt_clear) begin
            full_cnt  <= '0;
            empty_cnt <= '0;
            read_cnt  <= '0;
        end else begin
            full_cnt  <= full_cnt  + CNT_BITS'(sat_step(full,  &full_cnt));
            empty_cnt <= empty_cnt + CNT_BITS'(sat_step(empty, &empty_cnt));
            read_cnt  <= read_cnt  + CNT_BITS'(sat_step(pop,   &read_cnt));
        end
    end

    // Run length of consecutive full cycles, capped at the stall threshold.
    always_comb begin
        run_next = '0;
        if (full) begin
            run_next = (run == STALL_C) ? run : run + 1'b1;
        end
    end

    // Stall flag. It follows the run length and drops the cycle after full ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run             <= '0;
            stall_condition <= 1'b0;
        end else begin
            run             <= run_next;
            stall_condition <= (run_next >= STALL_C);
        end
    end

endmodule

// File: rtl/leaf_port_bridge.sv
// Buffered bridge between the leaf interface vld/ack buses and kernel AXI-stream ports.
// Outbound channels hide their head while the interface is in resend mode.
module leaf_port_bridge
    import leaf_port_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int CNT_BITS      = 32,
    parameter int STALL_CNT     = 1
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    input  logic                                  resend,
    input  logic                                  cnt_clear,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_TDATA,
    output logic [NUM_IN_PORTS-1:0]               Input_TVALID,
    input  logic [NUM_IN_PORTS-1:0]               Input_TREADY,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_TDATA,
    input  logic [NUM_OUT_PORTS-1:0]              Output_TVALID,
    output logic [NUM_OUT_PORTS-1:0]              Output_TREADY,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]      full_cnt_in,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]      empty_cnt_in,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]      read_cnt_in,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     full_cnt_out,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     empty_cnt_out,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     read_cnt_out,
    output logic [NUM_IN_PORTS-1:0]               stall_condition_in,
    output logic [NUM_OUT_PORTS-1:0]              stall_condition_out
);

    // Interface to kernel. These channels are never gated.
    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        leaf_chan_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .CNT_BITS     (CNT_BITS),
            .STALL_CNT    (STALL_CNT)
        ) u_chan (
            .clk             (ap_clk),
            .rst_n           (ap_rst_n),
            .cnt_clear       (cnt_clear),
            .rd_gate         (1'b0),
            .wr_data         (din_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_valid        (vld_interface2user[i]),
            .wr_ready        (ack_user2interface[i]),
            .rd_data         (Input_TDATA[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_valid        (Input_TVALID[i]),
            .rd_ready        (Input_TREADY[i]),
            .full_cnt        (full_cnt_in[i*CNT_BITS +: CNT_BITS]),
            .empty_cnt       (empty_cnt_in[i*CNT_BITS +: CNT_BITS]),
            .read_cnt        (read_cnt_in[i*CNT_BITS +: CNT_BITS]),
            .stall_condition (stall_condition_in[i])
        );
    end

    // Kernel to interface. Resend freezes the head until the interface leaves resend mode.
    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        leaf_chan_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .CNT_BITS     (CNT_BITS),
            .STALL_CNT    (STALL_CNT)
        ) u_chan (
            .clk             (ap_clk),
            .rst_n           (ap_rst_n),
            .cnt_clear       (cnt_clear),
            .rd_gate         (resend),
            .wr_data         (Output_TDATA[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_valid        (Output_TVALID[j]),
            .wr_ready        (Output_TREADY[j]),
            .rd_data         (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_valid        (vld_user2interface[j]),
            .rd_ready        (ack_interface2user[j]),
            .full_cnt        (full_cnt_out[j*CNT_BITS +: CNT_BITS]),
            .empty_cnt       (empty_cnt_out[j*CNT_BITS +: CNT_BITS]),
            .read_cnt        (read_cnt_out[j*CNT_BITS +: CNT_BITS]),
            .stall_condition (stall_condition_out[j])
        );
    end

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Self-checking bench for leaf_port_bridge: directed steps plus random traffic,
// compared every cycle against a queue-based model of each channel.
module tb_leaf_port_bridge;

    localparam int PW    = 32;
    localparam int NIN   = 3;
    localparam int NOUT  = 2;
    localparam int NCH   = NIN + NOUT;
    localparam int DEPTH = 4;
    localparam int CB    = 4;
    localparam int STALL = 2;
    localparam int CMAX  = (1 << CB) - 1;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n;
    logic                 resend;
    logic                 cnt_clear;
    logic [NIN*PW-1:0]    din_leaf_interface2user;
    logic [NIN-1:0]       vld_interface2user;
    logic [NIN-1:0]       ack_user2interface;
    logic [NIN*PW-1:0]    Input_TDATA;
    logic [NIN-1:0]       Input_TVALID;
    logic [NIN-1:0]       Input_TREADY;
    logic [NOUT*PW-1:0]   Output_TDATA;
    logic [NOUT-1:0]      Output_TVALID;
    logic [NOUT-1:0]      Output_TREADY;
    logic [NOUT*PW-1:0]   din_leaf_user2interface;
    logic [NOUT-1:0]      vld_user2interface;
    logic [NOUT-1:0]      ack_interface2user;
    logic [NIN*CB-1:0]    full_cnt_in, empty_cnt_in, read_cnt_in;
    logic [NOUT*CB-1:0]   full_cnt_out, empty_cnt_out, read_cnt_out;
    logic [NIN-1:0]       stall_condition_in;
    logic [NOUT-1:0]      stall_condition_out;

    leaf_port_bridge #(
        .PAYLOAD_BITS (PW),
        .NUM_IN_PORTS (NIN),
        .NUM_OUT_PORTS(NOUT),
        .FIFO_DEPTH   (DEPTH),
        .CNT_BITS     (CB),
        .STALL_CNT    (STALL)
    ) dut (
        .ap_clk                  (ap_clk),
        .ap_rst_n                (ap_rst_n),
        .resend                  (resend),
        .cnt_clear               (cnt_clear),
        .din_leaf_interface2user (din_leaf_interface2user),
        .vld_interface2user      (vld_interface2user),
        .ack_user2interface      (ack_user2interface),
        .Input_TDATA             (Input_TDATA),
        .Input_TVALID            (Input_TVALID),
        .Input_TREADY            (Input_TREADY),
        .Output_TDATA            (Output_TDATA),
        .Output_TVALID           (Output_TVALID),
        .Output_TREADY           (Output_TREADY),
        .din_leaf_user2interface (din_leaf_user2interface),
        .vld_user2interface      (vld_user2interface),
        .ack_interface2user      (ack_interface2user),
        .full_cnt_in             (full_cnt_in),
        .empty_cnt_in            (empty_cnt_in),
        .read_cnt_in             (read_cnt_in),
        .full_cnt_out            (full_cnt_out),
        .empty_cnt_out           (empty_cnt_out),
        .read_cnt_out            (read_cnt_out),
        .stall_condition_in      (stall_condition_in),
        .stall_condition_out     (stall_condition_out)
    );

    always #5 ap_clk = ~ap_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: channels 0..NIN-1 are inbound, NIN.. are outbound.
    logic [PW-1:0] mq [NCH][$];
    int  m_full  [NCH];
    int  m_empty [NCH];
    int  m_read  [NCH];
    int  m_run   [NCH];
    bit  m_ready_ok;

    task automatic check(input string tag, input int ch, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s ch%0d observed=0x%0h expected=0x%0h", tag, ch, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            mq[ch].delete();
            m_full[ch]  = 0;
            m_empty[ch] = 0;
            m_read[ch]  = 0;
            m_run[ch]   = 0;
        end
        m_ready_ok = 1'b0;
    endtask

    function automatic int sat_inc(input int v, input bit inc);
        return (inc && v < CMAX) ? v + 1 : v;
    endfunction

    // One clock edge of the model, using the inputs the bench is driving.
    task automatic model_step();
        int            sz;
        int            oi;
        bit            outb, full, pop, push, wv, rr;
        logic [PW-1:0] din;
        if (!ap_rst_n) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            outb = (ch >= NIN);
            oi   = outb ? ch - NIN : 0;
            sz   = mq[ch].size();
            full = (sz == DEPTH);
            if (outb) begin
                wv  = Output_TVALID[oi];
                rr  = ack_interface2user[oi] && !resend;
                din = Output_TDATA[oi*PW +: PW];
            end else begin
                wv  = vld_interface2user[ch];
                rr  = Input_TREADY[ch];
                din = din_leaf_interface2user[ch*PW +: PW];
            end
            pop  = (sz > 0) && rr;
            push = wv && m_ready_ok && !full;
            if (cnt_clear) begin
                m_full[ch]  = 0;
                m_empty[ch] = 0;
                m_read[ch]  = 0;
            end else begin
                m_full[ch]  = sat_inc(m_full[ch],  full);
                m_empty[ch] = sat_inc(m_empty[ch], sz == 0);
                m_read[ch]  = sat_inc(m_read[ch],  pop);
            end
            m_run[ch] = full ? m_run[ch] + 1 : 0;
            if (pop)  void'(mq[ch].pop_front());
            if (push) mq[ch].push_back(din);
        end
        m_ready_ok = 1'b1;
    endtask

    function automatic logic [63:0] dut_valid(input int ch);
        if (ch < NIN) return 64'(Input_TVALID[ch]);
        return 64'(vld_user2interface[ch-NIN]);
    endfunction

    function automatic logic [63:0] dut_data(input int ch);
        if (ch < NIN) return 64'(Input_TDATA[ch*PW +: PW]);
        return 64'(din_leaf_user2interface[(ch-NIN)*PW +: PW]);
    endfunction

    function automatic logic [63:0] dut_ready(input int ch);
        if (ch < NIN) return 64'(ack_user2interface[ch]);
        return 64'(Output_TREADY[ch-NIN]);
    endfunction

    function automatic logic [63:0] dut_cnt(input int ch, input int kind);
        if (ch < NIN) begin
            case (kind)
                0:       return 64'(full_cnt_in[ch*CB +: CB]);
                1:       return 64'(empty_cnt_in[ch*CB +: CB]);
                default: return 64'(read_cnt_in[ch*CB +: CB]);
            endcase
        end
        case (kind)
            0:       return 64'(full_cnt_out[(ch-NIN)*CB +: CB]);
            1:       return 64'(empty_cnt_out[(ch-NIN)*CB +: CB]);
            default: return 64'(read_cnt_out[(ch-NIN)*CB +: CB]);
        endcase
    endfunction

    function automatic logic [63:0] dut_stall(input int ch);
        if (ch < NIN) return 64'(stall_condition_in[ch]);
        return 64'(stall_condition_out[ch-NIN]);
    endfunction

    // Compare every channel's visible outputs against the model.
    task automatic check_all();
        int sz;
        bit outb;
        for (int ch = 0; ch < NCH; ch++) begin
            sz   = mq[ch].size();
            outb = (ch >= NIN);
            check("valid", ch, dut_valid(ch), 64'((sz > 0) && !(outb && resend)));
            check("data",  ch, dut_data(ch),  (sz > 0) ? 64'(mq[ch][0]) : 64'd0);
            if (m_ready_ok) check("ready", ch, dut_ready(ch), 64'(sz < DEPTH));
            check("full_cnt",  ch, dut_cnt(ch, 0), 64'(m_full[ch]));
            check("empty_cnt", ch, dut_cnt(ch, 1), 64'(m_empty[ch]));
            check("read_cnt",  ch, dut_cnt(ch, 2), 64'(m_read[ch]));
            check("stall",     ch, dut_stall(ch),  64'(m_run[ch] >= STALL));
        end
    endtask

    // Advance one cycle: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge ap_clk);
        model_step();
        @(negedge ap_clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        resend                  = 1'b0;
        cnt_clear               = 1'b0;
        din_leaf_interface2user = '0;
        vld_interface2user      = '0;
        Input_TREADY            = '0;
        Output_TDATA            = '0;
        Output_TVALID           = '0;
        ack_interface2user      = '0;
    endtask

    int nxt [NIN];
    int rcv [NIN];
    bit acc [NIN];

    initial begin
        // Reset state.
        ap_rst_n = 1'b0;
        idle_inputs();
        model_reset();
        ticks(2);
        ap_rst_n = 1'b1;
        ticks(4);

        // Single word through inbound channel 0.
        vld_interface2user[0]        = 1'b1;
        din_leaf_interface2user[31:0] = 32'hDEADBEEF;
        tick();
        check("single_valid", 0, 64'(Input_TVALID[0]), 64'd1);
        check("single_data",  0, 64'(Input_TDATA[31:0]), 64'hDEADBEEF);
        vld_interface2user[0] = 1'b0;
        Input_TREADY[0]       = 1'b1;
        tick();
        check("single_read_cnt", 0, 64'(read_cnt_in[CB-1:0]), 64'd1);
        Input_TREADY[0] = 1'b0;

        // Fill channel 0 with six offers while the kernel is stalled, then drain.
        for (int i = 0; i < 6; i++) begin
            vld_interface2user[0]         = 1'b1;
            din_leaf_interface2user[31:0] = 32'hA0 + 32'(i);
            tick();
        end
        vld_interface2user[0] = 1'b0;
        check("fill_ack",      0, 64'(ack_user2interface[0]), 64'd0);
        check("fill_full_cnt", 0, 64'(full_cnt_in[CB-1:0]), 64'd2);
        check("fill_stall",    0, 64'(stall_condition_in[0]), 64'd1);
        Input_TREADY[0] = 1'b1;
        ticks(6);
        check("drain_valid", 0, 64'(Input_TVALID[0]), 64'd0);
        check("drain_stall", 0, 64'(stall_condition_in[0]), 64'd0);
        Input_TREADY[0] = 1'b0;

        // Resend holds the outbound head.
        resend                = 1'b1;
        ack_interface2user[0] = 1'b1;
        Output_TVALID[0]      = 1'b1;
        Output_TDATA[31:0]    = 32'h11;
        tick();
        Output_TDATA[31:0]    = 32'h22;
        tick();
        Output_TVALID[0]      = 1'b0;
        ticks(10);
        check("resend_vld",  NIN, 64'(vld_user2interface[0]), 64'd0);
        check("resend_data", NIN, 64'(din_leaf_user2interface[31:0]), 64'h11);
        resend = 1'b0;
        tick();
        check("resend_next", NIN, 64'(din_leaf_user2interface[31:0]), 64'h22);
        tick();
        check("resend_read_cnt", NIN, 64'(read_cnt_out[CB-1:0]), 64'd2);
        ack_interface2user[0] = 1'b0;

        // Counter saturation and clear while full.
        check("empty_sat", NIN + 1, 64'(empty_cnt_out[CB +: CB]), 64'(CMAX));
        Output_TVALID[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Output_TDATA[PW +: PW] = 32'hC0 + 32'(i);
            tick();
        end
        Output_TVALID[1] = 1'b0;
        ticks(3);
        cnt_clear = 1'b1;
        tick();
        check("clear_zero", NIN + 1, 64'(full_cnt_out[CB +: CB]), 64'd0);
        cnt_clear = 1'b0;
        tick();
        check("clear_resume", NIN + 1, 64'(full_cnt_out[CB +: CB]), 64'd1);
        ack_interface2user[1] = 1'b1;
        ticks(6);
        ack_interface2user[1] = 1'b0;

        // Random concurrent traffic on every channel.
        for (int ch = 0; ch < NIN; ch++) begin
            nxt[ch] = 0;
            rcv[ch] = 0;
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (rcv[0] >= 1000 && rcv[1] >= 1000 && rcv[2] >= 1000) break;
            for (int ch = 0; ch < NIN; ch++) begin
                vld_interface2user[ch]              = ($urandom_range(1) == 1) && (nxt[ch] < 1000);
                din_leaf_interface2user[ch*PW +: PW] = {8'(ch), 24'(nxt[ch])};
                Input_TREADY[ch]                    = ($urandom_range(1) == 1);
                acc[ch] = vld_interface2user[ch] && m_ready_ok && (mq[ch].size() < DEPTH);
                if (Input_TVALID[ch] && Input_TREADY[ch]) begin
                    check("order", ch, 64'(Input_TDATA[ch*PW +: PW]), 64'({8'(ch), 24'(rcv[ch])}));
                    rcv[ch]++;
                end
            end
            for (int j = 0; j < NOUT; j++) begin
                Output_TVALID[j]        = ($urandom_range(1) == 1);
                Output_TDATA[j*PW +: PW] = $urandom;
                ack_interface2user[j]   = ($urandom_range(1) == 1);
            end
            resend = ($urandom_range(7) == 0);
            tick();
            for (int ch = 0; ch < NIN; ch++) if (acc[ch]) nxt[ch]++;
        end
        for (int ch = 0; ch < NIN; ch++) begin
            check("words_received", ch, 64'(rcv[ch]), 64'd1000);
        end

        // Drain everything, then buffer three words and reset asynchronously.
        idle_inputs();
        Input_TREADY       = '1;
        ack_interface2user = '1;
        ticks(6);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            vld_interface2user[0]         = 1'b1;
            din_leaf_interface2user[31:0] = 32'hE0 + 32'(i);
            tick();
        end
        vld_interface2user[0] = 1'b0;
        tick();
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_valid", 0, 64'(Input_TVALID[0]), 64'd0);
        check("async_data",  0, 64'(Input_TDATA[31:0]), 64'd0);
        model_reset();
        check_all();
        ticks(2);
        ap_rst_n = 1'b1;
        tick();
        check("post_reset_ack",   0, 64'(ack_user2interface), 64'((1 << NIN) - 1));
        check("post_reset_tready", 0, 64'(Output_TREADY), 64'((1 << NOUT) - 1));
        check("post_reset_valid", 0, 64'(Input_TVALID), 64'd0);
        ticks(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
